// File: rtl/dmem_pkg.sv
// Shared address map and region decode for the data-side memory/MMIO responder.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
  localparam logic [7:0] OFF_MTIME    = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // RAM occupies the bottom 4*2^addr_w bytes; MMIO is the 256-byte page at MMIO_BASE.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int unsigned addr_w);
    region_e r;
    r = REG_NONE;
    if ((addr >> (addr_w + 2)) == '0) begin
      r = REG_RAM;
    end else if (addr[31:8] == MMIO_BASE[31:8]) begin
      r = REG_MMIO;
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running compare timer: MTIME, MTIMECMP and a sticky W1C match flag.
// Only present when DMEM_TIMER_EN is defined.
`ifdef DMEM_TIMER_EN
module mmio_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtime_we_i,
  input  logic        cmp_we_i,
  input  logic        status_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] mtime_o,
  output logic [31:0] mtimecmp_o,
  output logic        flag_o
);

  logic [31:0] mtime_q, mtime_d;
  logic [31:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic        match;

  // A set from a registered match overrides a simultaneous W1C clear.
  always_comb begin
    match   = (mtime_q == cmp_q);
    mtime_d = mtime_we_i ? wdata_i : mtime_q + 32'd1;
    cmp_d   = cmp_we_i ? wdata_i : cmp_q;
    flag_d  = match | (flag_q & ~(status_we_i & wdata_i[0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
      cmp_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = cmp_q;
  assign flag_o     = flag_q;

endmodule
`endif

// File: rtl/data_memory_mmio.sv
// Data-side responder: word RAM plus GPIO/timer MMIO page, zero-latency reads.
// The timer block is built only when DMEM_TIMER_EN is defined.
module data_memory_mmio
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_ALUResultM,
  input  logic [31:0]       i_WriteDataM,
  input  logic              i_MemWriteM,
  output logic [31:0]       o_ReadDataM,
  input  logic [GPIO_W-1:0] i_gpio_in,
  output logic [GPIO_W-1:0] o_gpio_out,
  output logic              o_timer_irq
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  logic [31:0]       mem [DEPTH_WORDS];
  region_e           region;
  logic [ADDR_W-1:0] ram_idx;
  logic [7:0]        mmio_off;
  logic              wr_ok;
  logic              ram_we;
  logic              mmio_we;
  logic              unused_addr_lsb;

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [31:0]       rdata;

  assign region          = decode_region(i_ALUResultM, ADDR_W);
  assign ram_idx         = i_ALUResultM[ADDR_W+1:2];
  assign mmio_off        = {i_ALUResultM[7:2], 2'b00};
  assign unused_addr_lsb = ^i_ALUResultM[1:0];

  assign wr_ok   = i_MemWriteM & ~rst;
  assign ram_we  = wr_ok && (region == REG_RAM);
  assign mmio_we = wr_ok && (region == REG_MMIO);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= i_WriteDataM;
    end
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (mmio_we && (mmio_off == OFF_GPIO_OUT)) begin
      gpio_out_d = i_WriteDataM[GPIO_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= i_gpio_in;
      sync2_q    <= sync1_q;
    end
  end

  assign o_gpio_out = gpio_out_q;

`ifdef DMEM_TIMER_EN
  logic [31:0] mtime;
  logic [31:0] mtimecmp;
  logic        flag;
  logic        mtime_we;
  logic        cmp_we;
  logic        status_we;

  assign mtime_we  = mmio_we && (mmio_off == OFF_MTIME);
  assign cmp_we    = mmio_we && (mmio_off == OFF_MTIMECMP);
  assign status_we = mmio_we && (mmio_off == OFF_STATUS);

  mmio_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .mtime_we_i  (mtime_we),
    .cmp_we_i    (cmp_we),
    .status_we_i (status_we),
    .wdata_i     (i_WriteDataM),
    .mtime_o     (mtime),
    .mtimecmp_o  (mtimecmp),
    .flag_o      (flag)
  );

  assign o_timer_irq = flag;
`else
  assign o_timer_irq = 1'b0;
`endif

  // Read mux sees pre-edge state, so a same-cycle write returns the old value.
  always_comb begin
    rdata = '0;
    if (!rst) begin
      case (region)
        REG_RAM: rdata = mem[ram_idx];
        REG_MMIO: begin
          case (mmio_off)
            OFF_GPIO_OUT: rdata[GPIO_W-1:0] = gpio_out_q;
            OFF_GPIO_IN:  rdata[GPIO_W-1:0] = sync2_q;
`ifdef DMEM_TIMER_EN
            OFF_MTIME:    rdata = mtime;
            OFF_MTIMECMP: rdata = mtimecmp;
            OFF_STATUS:   rdata[0] = flag;
`endif
            default:      rdata = '0;
          endcase
        end
        default: rdata = '0;
      endcase
    end
  end

  assign o_ReadDataM = rdata;

endmodule
